// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the toggle (2-phase) handshake transmitter and its receiver.
package toggle_hs_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } hs_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit into the clk_i domain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_handshake_tx.sv
// Event-to-toggle handshake transmitter: queues event pulses in a saturating
// counter and launches one 2-phase request per event, one outstanding at a time.
module toggle_handshake_tx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             event_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic             req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hs_state_e        state_q, state_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_s;
  logic             launch;
  logic             drop;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (ack_i),
    .q_o  (ack_s)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          launch  = 1'b1;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A launch frees a slot in the same cycle, so a full counter only drops
  // an event when nothing is being launched.
  always_comb begin
    drop  = event_i && (cnt_q == CNT_MAX) && !launch;
    cnt_d = cnt_q;
    if (event_i && !launch && !drop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (launch && !event_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_o      = req_q;
  assign busy_o     = (state_q == WAIT_ACK);
  assign done_o     = done_q;
  assign pending_o  = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
// Directed bench for toggle_handshake_tx: a vector table for one full handshake
// pair plus hand-written sequences for queuing, saturation, spurious ack and reset.
module tb_toggle_handshake_tx;

  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             event_i;
  logic             ack_i;
  logic             clr_i;
  logic             req_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] pending_o;
  logic             overflow_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  hist;
  logic        auto_ack;

  toggle_handshake_tx #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .event_i   (event_i),
    .ack_i     (ack_i),
    .clr_i     (clr_i),
    .req_o     (req_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       ev;
    logic       ack;
    logic [7:0] exp; // {req, busy, done, ovf, pending[3:0]}
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic ev, logic ack, logic req, logic busy, logic done,
                              logic [3:0] pend);
    vec_t v;
    v.ev  = ev;
    v.ack = ack;
    v.exp = {req, busy, done, 1'b0, pend};
    return v;
  endfunction

  // Far side modelled as echoing req_o back three cycles later when enabled.
  task automatic tick();
    @(posedge clk_i);
    #1;
    hist = {hist[6:0], req_o};
    if (auto_ack) ack_i = hist[3];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i    = 1'b1;
    event_i  = 1'b0;
    clr_i    = 1'b0;
    ack_i    = 1'b0;
    hist     = '0;
    auto_ack = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int unsigned peak, toggles, dones;
    logic prev_req;
    logic got_done;

    vecs[0]  = mk(1, 0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 0, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1, 0, 0);
    vecs[5]  = mk(0, 1, 1, 1, 0, 0);
    vecs[6]  = mk(0, 1, 1, 1, 0, 0);
    vecs[7]  = mk(0, 1, 1, 0, 1, 0);
    vecs[8]  = mk(0, 1, 1, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 0, 0, 1);
    vecs[10] = mk(0, 1, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0);

    do_reset();
    chk("reset_state", {req_o, busy_o, done_o, overflow_o, pending_o}, 8'h00);

    // Single event, ack returned 3 cycles after req, then a second handshake back to 0.
    for (int i = 0; i < 15; i++) begin
      event_i = vecs[i].ev;
      ack_i   = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d", i), {req_o, busy_o, done_o, overflow_o, pending_o}, vecs[i].exp);
    end

    // Five back-to-back events with an echoing far side.
    do_reset();
    auto_ack = 1'b1;
    peak = 0; toggles = 0; dones = 0;
    for (int c = 0; c < 300; c++) begin
      event_i  = (c < 5);
      prev_req = req_o;
      tick();
      if (req_o != prev_req) toggles++;
      if (done_o) dones++;
      if (pending_o > peak) peak = pending_o;
      if (c >= 5 && dones == 5 && !busy_o && pending_o == 0) break;
    end
    event_i = 1'b0;
    chk("burst_peak", peak, 4);
    chk("burst_toggles", toggles, 5);
    chk("burst_dones", dones, 5);
    chk("burst_final_req", req_o, 1);

    // Saturation with ack withheld: 17 events, one dropped.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      event_i = 1'b1;
      tick();
    end
    event_i = 1'b0;
    chk("sat_pending", pending_o, 15);
    chk("sat_overflow", overflow_o, 1);
    chk("sat_req", req_o, 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("sat_clr", overflow_o, 0);
    chk("sat_pending_hold", pending_o, 15);
    event_i = 1'b1;
    clr_i   = 1'b1;
    tick();
    event_i = 1'b0;
    clr_i   = 1'b0;
    chk("drop_beats_clr", overflow_o, 1);

    // Event on the launch cycle leaves the count unchanged.
    do_reset();
    event_i = 1'b1;
    tick();
    chk("launch_pre_pending", pending_o, 1);
    tick();
    event_i = 1'b0;
    chk("launch_coincide", {req_o, busy_o, pending_o}, {1'b1, 1'b1, 4'd1});

    // Spurious ack in IDLE is ignored.
    do_reset();
    ack_i    = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_o || busy_o || req_o) got_done = 1'b1;
    end
    chk("spurious_ignored", got_done, 0);
    event_i  = 1'b1;
    tick();
    event_i  = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("spurious_next_done", got_done, 1);
    tick();
    chk("spurious_next_idle", {req_o, busy_o}, 2'b10);

    // Reset mid-handshake with three events queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      event_i = 1'b1;
      tick();
    end
    event_i = 1'b0;
    chk("pre_rst_state", {req_o, busy_o, pending_o}, {1'b1, 1'b1, 4'd3});
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_outputs", {req_o, busy_o, done_o, overflow_o, pending_o}, 8'h00);
    ack_i = 1'b0;
    hist  = '0;
    tick();
    rst_i    = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_o || busy_o || pending_o != 0) got_done = 1'b1;
    end
    chk("post_rst_quiet", got_done, 0);
    event_i = 1'b1;
    tick();
    event_i = 1'b0;
    tick();
    chk("post_rst_launch", {req_o, busy_o}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_handshake_tx.md
TOGGLE_HANDSHAKE_TX -- requirements
Module: toggle_handshake_tx

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the pending-event counter (max 2^CNT_W-1 queued events).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of ack synchronizer flops (legal range 2..4).
REQ-003 SHALL have port clk_i  input  1  sole clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port event_i  input  1  single-cycle event pulse, synchronous to clk_i.
REQ-006 SHALL have port ack_i  input  1  2-phase acknowledge toggle from the far clock domain, asynchronous to clk_i.
REQ-007 SHALL have port clr_i  input  1  synchronous clear of the sticky overflow flag.
REQ-008 SHALL have port req_o  output  1  2-phase request toggle to the far domain, driven directly from a flop.
REQ-009 SHALL have port busy_o  output  1  high while a request is outstanding.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse on completion of a handshake.
REQ-011 SHALL have port pending_o  output  CNT_W  events accepted but not yet launched.
REQ-012 SHALL have port overflow_o  output  1  sticky: at least one event was dropped.

Function
REQ-013 SHALL pass ack_i through SYNC_STAGES flops to form ack_s; no other logic may sample ack_i.
REQ-014 SHALL implement FSM states IDLE and WAIT_ACK.
REQ-015 IDLE with pending_o>0: at the next edge, toggle req_o, decrement the counter, and enter WAIT_ACK.
REQ-016 WAIT_ACK: when ack_s==req_o, enter IDLE at the next edge and assert done_o for exactly that one cycle.
REQ-017 busy_o SHALL equal (state==WAIT_ACK).
REQ-018 An event_i pulse SHALL increment the counter at the capturing edge; req_o toggles no earlier than the following edge.
REQ-019 Simultaneous event_i and launch SHALL leave the counter unchanged, with no loss.
REQ-020 event_i while counter==2^CNT_W-1 and no launch in that cycle: the event is dropped, the counter holds (no wrap), and overflow_o sets.
REQ-021 overflow_o SHALL clear on clr_i; if a drop coincides with clr_i, set wins.
REQ-022 ack_s changing while in IDLE (spurious) SHALL be ignored; the FSM compares only in WAIT_ACK.
REQ-023 Back-to-back queued events SHALL each produce a separate req_o toggle; at most one toggle is outstanding.

Reset
REQ-024 On rst_i assertion, immediately: state=IDLE, req_o=0, counter=0, overflow_o=0, done_o=0, all sync flops=0.
REQ-025 Reset mid-handshake SHALL abandon the outstanding request; the far side is required to be reset concurrently so that req_o and ack_i both return to 0.
REQ-026 Release of rst_i SHALL produce no req_o toggle unless an event arrives.

Structure
REQ-027 The FSM state enum (IDLE, WAIT_ACK) SHALL live in shared package toggle_hs_pkg, for reuse by the matching receiver.
REQ-028 The ack synchronizer SHALL be sub-module sync_ff (parameter STAGES), with its flops marked ASYNC_REG.
REQ-029 All other logic SHALL reside in toggle_handshake_tx.

Verification
REQ-030 Single event, ack_i toggles 3 cycles after req_o: req_o goes 0->1 one edge after the capture edge, done_o pulses once, busy_o is high from the launch until done, pending_o returns to 0.
REQ-031 5 consecutive event pulses: pending_o peaks at 4, exactly 5 req_o toggles occur, 5 done_o pulses occur, final req_o=1.
REQ-032 CNT_W=4, 17 events with ack withheld: the counter saturates at 15, overflow_o=1, exactly 1 event is dropped; clr_i then clears overflow_o.
REQ-033 event_i on the launch cycle with pending_o=1: pending_o remains 1 after the edge.
REQ-034 Spurious ack_i toggle in IDLE: no done_o, no state change; the next event still completes normally.
REQ-035 rst_i asserted during WAIT_ACK with pending_o=3: all outputs are 0 immediately; after release, no toggle occurs until a new event arrives.
